// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared types and constants for the iterative divider.
//   DATA_W        operand width (also the number of RUN iterations)
//   CNT_W         iteration counter width
//   div_state_e   FSM encoding: IDLE=0, ZERO=1, RUN=2, DONE=3
//   ALUCTRL_DIV*  E-stage alucontrol codes used by the glue to form start/signed_div
//   div_result_t  {hi = remainder, lo = quotient}
package div_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam logic [3:0] ALUCTRL_DIV  = 4'b1100;
    localparam logic [3:0] ALUCTRL_DIVU = 4'b1101;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } div_result_t;

    // Two's-complement negate when neg is set.
    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   i_rem, i_quo  current partial remainder / shifting dividend-quotient register
//   i_div         divisor magnitude
//   o_rem, o_quo  values after shifting in one dividend bit and one quotient bit
module div_step
    import div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_part;
    logic [DATA_W:0] w_diff;

    // Shifted remainder can reach 2*div-1, so the trial needs one extra bit.
    assign w_part = {i_rem, i_quo[DATA_W-1]};
    assign w_diff = w_part - {1'b0, i_div};

    // Sign bit of the trial result decides restore vs. keep.
    assign o_rem = w_diff[DATA_W] ? w_part[DATA_W-1:0] : w_diff[DATA_W-1:0];
    assign o_quo = {i_quo[DATA_W-2:0], ~w_diff[DATA_W]};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU unit for the execute stage.
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   start       E stage holds a DIV/DIVU with ready operands (level)
//   signed_div  1 = DIV, 0 = DIVU
//   annul       E-stage flush; cancels any operation
//   a, b        dividend / divisor
//   busy        stall request (combinational)
//   done        one-cycle result-valid pulse (registered)
//   result      {hi = remainder, lo = quotient}, registered and held
module div_unit
    import div_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
);

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_done;
    div_result_t       r_result;

    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;

    assign w_accept = start & ~annul & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_a_mag  = cond_neg(signed_div & a[DATA_W-1], a);
    assign w_b_mag  = cond_neg(signed_div & b[DATA_W-1], b);

    // Stall is withdrawn the moment the stage is flushed.
    assign busy   = w_accept | (~annul & ((r_state == ST_ZERO) | (r_state == ST_RUN)));
    assign done   = r_done;
    assign result = r_result;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // FSM, datapath registers and result/done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (annul) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_sign_q <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
                            r_sign_r <= signed_div & a[DATA_W-1];
                            r_quo    <= w_a_mag;
                            r_div    <= w_b_mag;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_state  <= (b == '0) ? ST_ZERO : ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ZERO: begin
                        // r_quo still holds |a|; re-applying the sign recovers raw a.
                        r_result <= '{hi: cond_neg(r_sign_r, r_quo), lo: '1};
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    ST_RUN: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= '{hi: cond_neg(r_sign_r, w_rem_nxt),
                                          lo: cond_neg(r_sign_q, w_quo_nxt)};
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        sg;
        logic [63:0] exp;   // {hi, lo}
        int          lat;
        string       nm;
    } vec_t;

    typedef struct {
        string       nm;
        logic [63:0] res;
        int          lat;
    } sb_t;

    vec_t        vecs[15];
    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_res = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Independent reference: wide signed/unsigned arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic sg);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Drive start for one cycle from the current time; returns at T+1 +1.
    task automatic drive_start(input logic [31:0] va, input logic [31:0] vb, input logic sg,
                               input bit push, input logic [63:0] er, input int lat, input string nm);
        a = va;
        b = vb;
        signed_div = sg;
        start = 1'b1;
        #1;
        chk({nm, "_busy_accept"}, 64'(busy), 64'd1);
        if (push) sb_q.push_back('{nm: nm, res: er, lat: lat});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare.
    task automatic wait_done();
        int  n;
        int  busy_bad;
        sb_t e;
        n = 1;
        busy_bad = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got done with empty scoreboard, expected no done");
        end else begin
            e = sb_q.pop_front();
            chk({e.nm, "_latency"}, 64'(n), 64'(e.lat));
            chk({e.nm, "_result"}, result, e.res);
            chk({e.nm, "_busy_run_bad_cycles"}, 64'(busy_bad), 64'd0);
            chk({e.nm, "_busy_at_done"}, 64'(busy), 64'd0);
            last_res = e.res;
        end
    endtask

    task automatic idle_cycles(input int n, input string nm);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen++;
        end
        chk({nm, "_done_cycles"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] re;

        rst = 1'b0;
        start = 1'b0;
        signed_div = 1'b0;
        annul = 1'b0;
        a = '0;
        b = '0;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,         32'd14},        33, "divu_100_7"};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF,  32'hFFFFFFFD},  33, "div_m7_2"};
        vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'd1,         32'hFFFFFFFD},  33, "div_7_m2"};
        vecs[3]  = '{32'h1234,      32'd0,         1'b1, {32'h1234,      32'hFFFFFFFF},  2,  "div_zero"};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'd0,         32'h80000000},  33, "div_ovf"};
        vecs[5]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'd0,         32'hFFFFFFFF},  33, "divu_max_1"};
        vecs[6]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, {32'd0,         32'd1},         33, "divu_max_max"};
        vecs[7]  = '{32'd5,         32'd0,         1'b0, {32'd5,         32'hFFFFFFFF},  2,  "divu_zero"};
        vecs[8]  = '{32'h80000000,  32'd0,         1'b1, {32'h80000000,  32'hFFFFFFFF},  2,  "div_zero_min"};
        vecs[9]  = '{32'hFFFFFFF9,  32'd0,         1'b1, {32'hFFFFFFF9,  32'hFFFFFFFF},  2,  "div_zero_neg"};
        vecs[10] = '{32'd3,         32'd10,        1'b0, {32'd3,         32'd0},         33, "divu_small"};
        vecs[11] = '{32'h80000000,  32'd2,         1'b1, {32'd0,         32'hC0000000},  33, "div_min_2"};
        vecs[12] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, {32'hFFFFFFFE,  32'd14},        33, "div_m100_m7"};
        vecs[13] = '{32'd100,       32'hFFFFFFF9,  1'b0, {32'd100,       32'd0},         33, "divu_100_big"};
        vecs[14] = '{32'hFFFFFFFE,  32'h80000000,  1'b0, {32'h7FFFFFFE,  32'd1},         33, "divu_top_bit"};

        // Reset state
        @(negedge clk);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(2, "post_reset");

        // Directed table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive_start(vecs[i].va, vecs[i].vb, vecs[i].sg, 1'b1, vecs[i].exp, vecs[i].lat, vecs[i].nm);
            wait_done();
            idle_cycles(2, {vecs[i].nm, "_pulse"});
        end

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            rs = 1'($urandom_range(0, 1));
            re = ref_div(ra, rb, rs);
            @(negedge clk);
            drive_start(ra, rb, rs, 1'b1, re, (rb == 32'd0) ? 2 : 33, $sformatf("rand%0d", i));
            wait_done();
            idle_cycles(1, "rand_pulse");
        end

        // Annul at T+10: no done, result held, next op completes
        @(negedge clk);
        drive_start(32'd1000, 32'd3, 1'b0, 1'b0, '0, 0, "annul_op");
        repeat (9) @(posedge clk);
        #2;
        annul = 1'b1;
        #1;
        chk("annul_busy_drop", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul_idle_busy", 64'(busy), 64'd0);
        chk("annul_no_done", 64'(done), 64'd0);
        idle_cycles(40, "annul_wait");
        chk("annul_result_held", result, last_res);
        @(negedge clk);
        drive_start(32'd1000, 32'd3, 1'b0, 1'b1, ref_div(32'd1000, 32'd3, 1'b0), 33, "after_annul");
        wait_done();
        idle_cycles(1, "after_annul_pulse");

        // start together with annul: not accepted
        @(negedge clk);
        a = 32'd50;
        b = 32'd5;
        signed_div = 1'b0;
        start = 1'b1;
        annul = 1'b1;
        #1;
        chk("start_annul_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        chk("start_annul_stays_idle", 64'(busy), 64'd0);
        idle_cycles(40, "start_annul_wait");

        // Reset at T+5 mid-RUN
        @(negedge clk);
        drive_start(32'd77, 32'd5, 1'b0, 1'b0, '0, 0, "reset_op");
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_result", result, last_res);
        rst = 1'b0;
        #1;
        chk("midrun_reset_result", result, 64'd0);
        chk("midrun_reset_done", 64'(done), 64'd0);
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(40, "post_midrun_reset");

        // Back-to-back: new start in each DONE cycle
        @(negedge clk);
        drive_start(32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14}, 33, "b2b_first");
        wait_done();
        drive_start(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "b2b_second");
        chk("b2b_prev_result_held", result, {32'd2, 32'd14});
        wait_done();
        drive_start(32'h55, 32'd0, 1'b0, 1'b1, {32'h55, 32'hFFFFFFFF}, 2, "b2b_zero");
        wait_done();
        drive_start(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, "b2b_after_zero");
        wait_done();
        idle_cycles(3, "b2b_end");

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
